// File: rtl/key_pkg.sv
// Shared types and constants for the push-button debounce slice.
package key_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } key_state_t;

    localparam logic KEY_ACTIVE_LEVEL = 1'b0;
    localparam int   SYNC_STAGES      = 2;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, debounce FSM, debounce and long-hold counters.
//
// state        | meaning
// RELEASED     | key accepted as released, waiting for a press sample
// PRESS_PEND   | press seen, counting stable cycles before accepting it
// PRESSED      | key accepted as pressed, hold counter running toward long press
// RELEASE_PEND | release seen, counting stable cycles before accepting it
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4_000_000,
    parameter int LONG_CYCLES     = 200_000_000
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYCLES);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    key_state_t             state;
    logic [CNT_W-1:0]       cnt;
    logic [HOLD_W-1:0]      hold_cnt;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], key_raw};
        end
    end

    assign s = (sync[SYNC_STAGES-1] == KEY_ACTIVE_LEVEL);

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state       <= RELEASED;
            cnt         <= '0;
            hold_cnt    <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            case (state)
                RELEASED: begin
                    if (s) begin
                        state <= PRESS_PEND;
                        cnt   <= '0;
                    end
                end
                PRESS_PEND: begin
                    if (!s) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= PRESSED;
                        cnt       <= '0;
                        hold_cnt  <= '0;
                        key_level <= 1'b1;
                        key_press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    // HOLD_SAT doubles as the "long already fired" marker for this press
                    if (!s) begin
                        state <= RELEASE_PEND;
                        cnt   <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= HOLD_SAT;
                        key_long <= 1'b1;
                    end else if (hold_cnt != HOLD_SAT) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RELEASE_PEND: begin
                    if (s) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state       <= RELEASED;
                        cnt         <= '0;
                        hold_cnt    <= '0;
                        key_level   <= 1'b0;
                        key_release <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= RELEASED;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Push-button bank conditioner: one independent debounce channel per raw key.
module key_debounce
    import key_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 4_000_000,
    parameter int LONG_CYCLES     = 200_000_000
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_ch (
            .sys_clk     (sys_clk),
            .rst_n       (rst_n),
            .key_raw     (key_raw[g]),
            .key_level   (key_level[g]),
            .key_press   (key_press[g]),
            .key_release (key_release[g]),
            .key_long    (key_long[g])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus random key activity against a run-length model.
module tb_key_debounce;

    localparam int N = 4;
    localparam int D = 8;
    localparam int L = 32;

    logic         sys_clk;
    logic         rst_n;
    logic [N-1:0] key_raw;
    logic [N-1:0] key_level, key_press, key_release, key_long;

    key_debounce #(
        .N_KEYS          (N),
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference: a change is accepted once the synchronised key has disagreed with the
    // accepted level for D+1 consecutive edges; long fires on the L-th steady pressed edge.
    bit [N-1:0]  ms1, ms2;
    logic [N-1:0] m_level, m_press, m_release, m_long;
    int          run  [N];
    int          hold [N];

    always @(posedge sys_clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                ms1[i] = 1'b1; ms2[i] = 1'b1;
                m_level[i] = 1'b0; m_press[i] = 1'b0; m_release[i] = 1'b0; m_long[i] = 1'b0;
                run[i] = 0; hold[i] = 0;
            end else begin
                bit sp;
                bit was_pend;
                sp = ~ms2[i];
                was_pend = (run[i] != 0);
                m_press[i] = 1'b0; m_release[i] = 1'b0; m_long[i] = 1'b0;
                if (sp != m_level[i]) begin
                    run[i] = run[i] + 1;
                    if (run[i] == D + 1) begin
                        m_level[i] = sp;
                        run[i] = 0;
                        hold[i] = 0;
                        if (sp) m_press[i] = 1'b1;
                        else    m_release[i] = 1'b1;
                    end
                end else begin
                    if (m_level[i] && !was_pend && hold[i] < L) begin
                        hold[i] = hold[i] + 1;
                        if (hold[i] == L) m_long[i] = 1'b1;
                    end
                    run[i] = 0;
                end
                ms2[i] = ms1[i];
                ms1[i] = key_raw[i];
            end
        end
    end

    int  press_cnt [N], rel_cnt [N], long_cnt [N];
    int  press_at  [N], long_at [N];
    bit  all_press_seen;

    task automatic clear_counts();
        for (int i = 0; i < N; i++) begin
            press_cnt[i] = 0; rel_cnt[i] = 0; long_cnt[i] = 0;
            press_at[i] = -1; long_at[i] = -1;
        end
        all_press_seen = 1'b0;
    endtask

    task automatic check_outputs();
        total++;
        assert (key_level === m_level) else begin
            bad++; $error("FAIL level cyc=%0d obs=%b exp=%b", cyc, key_level, m_level);
        end
        total++;
        assert (key_press === m_press) else begin
            bad++; $error("FAIL press cyc=%0d obs=%b exp=%b", cyc, key_press, m_press);
        end
        total++;
        assert (key_release === m_release) else begin
            bad++; $error("FAIL release cyc=%0d obs=%b exp=%b", cyc, key_release, m_release);
        end
        total++;
        assert (key_long === m_long) else begin
            bad++; $error("FAIL long cyc=%0d obs=%b exp=%b", cyc, key_long, m_long);
        end
    endtask

    task automatic expect_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++; $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [N-1:0] raw, input logic rstv);
        @(negedge sys_clk);
        key_raw = raw;
        rst_n   = rstv;
        @(posedge sys_clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (key_press[i])   begin press_cnt[i]++; press_at[i] = cyc; end
            if (key_release[i]) rel_cnt[i]++;
            if (key_long[i])    begin long_cnt[i]++; long_at[i] = cyc; end
        end
        if (key_press === 4'b1111) all_press_seen = 1'b1;
        check_outputs();
    endtask

    initial begin
        int k;
        logic [N-1:0] r;
        key_raw = '1;
        rst_n   = 1'b0;
        clear_counts();

        repeat (3) step(4'hF, 1'b0);
        expect_int("reset_outputs", int'({key_level, key_press, key_release, key_long}), 0);
        repeat (3) step(4'hF, 1'b1);

        // clean press on key 0
        clear_counts();
        step(4'hE, 1'b1);
        k = cyc;
        repeat (19) step(4'hE, 1'b1);
        expect_int("clean_press_count", press_cnt[0], 1);
        expect_int("clean_press_latency", press_at[0] - k, D + 2);
        expect_int("clean_other_bits", press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
        expect_int("clean_level", int'(key_level), 1);

        // short release glitch while key 0 held, then real release
        clear_counts();
        repeat (5) step(4'hF, 1'b1);
        repeat (15) step(4'hE, 1'b1);
        expect_int("glitch_no_release", rel_cnt[0], 0);
        repeat (12) step(4'hF, 1'b1);
        expect_int("release_count", rel_cnt[0], 1);
        expect_int("release_level", int'(key_level[0]), 0);

        // bouncing key 1, then settled press
        clear_counts();
        for (int j = 0; j < 30; j++) begin
            r = 4'b1101;
            r[1] = ((j / 3) % 2) != 0;
            step(r, 1'b1);
        end
        expect_int("bounce_no_press", press_cnt[1], 0);
        step(4'b1101, 1'b1);
        k = cyc;
        repeat (19) step(4'b1101, 1'b1);
        expect_int("bounce_press_count", press_cnt[1], 1);
        expect_int("bounce_press_latency", press_at[1] - k, D + 2);
        repeat (12) step(4'hF, 1'b1);

        // long press on key 2, then a hold too short for long
        clear_counts();
        repeat (60) step(4'b1011, 1'b1);
        expect_int("long_press_count", press_cnt[2], 1);
        expect_int("long_count", long_cnt[2], 1);
        expect_int("long_after_level", long_at[2] - press_at[2], L);
        repeat (15) step(4'hF, 1'b1);
        clear_counts();
        repeat (30) step(4'b1011, 1'b1);
        repeat (50) step(4'hF, 1'b1);
        expect_int("short_hold_no_long", long_cnt[2], 0);
        expect_int("short_hold_release", rel_cnt[2], 1);

        // all keys pressed together
        clear_counts();
        repeat (15) step(4'h0, 1'b1);
        expect_int("simul_press_all", int'(all_press_seen), 1);
        expect_int("simul_level", int'(key_level), 15);

        // reset while pressed; held key re-detected afterwards
        clear_counts();
        repeat (2) step(4'h0, 1'b0);
        expect_int("rst_mid_outputs", int'({key_level, key_press, key_release, key_long}), 0);
        step(4'h0, 1'b1);
        k = cyc;
        repeat (14) step(4'h0, 1'b1);
        expect_int("rst_no_release", rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3], 0);
        expect_int("rst_repress_latency", press_at[3] - k, D + 2);
        repeat (12) step(4'hF, 1'b1);

        // random key activity with occasional reset
        r = 4'hF;
        for (int j = 0; j < 4000; j++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 13) == 0) r[i] = ~r[i];
            step(r, ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
